// File: rtl/misr_sig_checker.sv
// Multiple-input signature register with a BIST compaction controller: seeds,
// compresses npat response vectors and compares against a golden signature.
module misr_sig_checker #(
  parameter int               WIDTH = 15,
  parameter int               NIN   = 3,
  parameter logic [WIDTH-1:0] POLY  = 15'h0003,
  parameter logic [WIDTH-1:0] SEED  = 15'h5DBB,
  parameter int               CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             en,
  input  logic [NIN-1:0]   din,
  input  logic [CNT_W-1:0] npat,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] npat_q;
  logic [WIDTH-1:0] golden_q;
  logic             pass_q;
  logic             accept_start;
  logic             accept_vec;
  logic             do_check;

  // One MISR step: Galois-style shift with feedback, then fold in the response.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [NIN-1:0]   d);
    logic [WIDTH-1:0] t;
    t = {s[WIDTH-2:0], 1'b0};
    if (s[WIDTH-1]) t = t ^ POLY;
    t[NIN-1:0] = t[NIN-1:0] ^ d;
    return t;
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    accept_vec   = 1'b0;
    do_check     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = (npat == '0) ? CHECK : RUN;
        end
      end
      RUN: begin
        if (en) begin
          accept_vec = 1'b1;
          if (cnt_q == npat_q - CNT_ONE) state_d = CHECK;
        end
      end
      CHECK: begin
        do_check = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sig_q    <= SEED;
      cnt_q    <= '0;
      npat_q   <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      if (accept_start) begin
        sig_q    <= SEED;
        cnt_q    <= '0;
        npat_q   <= npat;
        golden_q <= golden;
        pass_q   <= 1'b0;
      end
      if (accept_vec) begin
        sig_q <= misr_step(sig_q, din);
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (do_check) pass_q <= (sig_q == golden_q);
    end
  end

  assign sig  = sig_q;
  assign busy = (state_q == RUN) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = pass_q;

endmodule

// File: tb/tb_misr_sig_checker.sv
// Bench for misr_sig_checker: vector table, hand-written corner sequences and
// randomized sessions against a session-level signature model.
module tb_misr_sig_checker;

  localparam int         W     = 4;
  localparam int         NI    = 2;
  localparam logic [3:0] P     = 4'b0011;
  localparam logic [3:0] S0    = 4'b0001;
  localparam int         CW    = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          en;
  logic [NI-1:0] din;
  logic [CW-1:0] npat;
  logic [W-1:0]  golden;
  logic [W-1:0]  sig;
  logic          busy, done, pass;

  int checks   = 0;
  int failures = 0;

  misr_sig_checker #(.WIDTH(W), .NIN(NI), .POLY(P), .SEED(S0), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .en(en), .din(din), .npat(npat),
    .golden(golden), .sig(sig), .busy(busy), .done(done), .pass(pass)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          start;
    logic          en;
    logic [NI-1:0] din;
    logic [CW-1:0] npat;
    logic [W-1:0]  golden;
    logic [W-1:0]  esig;
    logic          ebusy, edone, epass;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic st, input logic e, input logic [1:0] d,
                     input logic [7:0] n, input logic [3:0] g, input logic [3:0] es,
                     input logic eb, input logic ed, input logic ep);
    row_t r;
    r.start = st; r.en = e; r.din = d; r.npat = n; r.golden = g;
    r.esig = es; r.ebusy = eb; r.edone = ed; r.epass = ep;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] es, input logic eb,
                         input logic ed, input logic ep);
    chk({name, ".sig"},  32'(sig),  32'(es));
    chk({name, ".busy"}, 32'(busy), 32'(eb));
    chk({name, ".done"}, 32'(done), 32'(ed));
    chk({name, ".pass"}, 32'(pass), 32'(ep));
  endtask

  task automatic cyc(input logic st, input logic e, input logic [1:0] d);
    start = st; en = e; din = d;
    @(posedge CLK); #1;
  endtask

  // Signature rule in plain arithmetic: multiply by x modulo the characteristic
  // polynomial, then add the response vector.
  function automatic int model_step(input int s, input int d);
    int t;
    t = (s * 2) % (1 << W);
    if (s >= (1 << (W - 1))) t = t ^ int'(P);
    return t ^ d;
  endfunction

  initial begin
    RST = 1'b0; start = 0; en = 0; din = '0; npat = '0; golden = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", S0, 0, 0, 0);
    RST = 1'b1;
    cyc(0, 1, 2'b11);
    chk_all("idle_en_ignored", S0, 0, 0, 0);

    // Table: basic compaction, zero input with feedback, restart from DONE, npat=0.
    add(1, 0, 2'b00, 3, 4'b1011, 4'b0001, 1, 0, 0);
    add(0, 1, 2'b01, 0, 4'b0000, 4'b0011, 1, 0, 0);
    add(0, 1, 2'b10, 0, 4'b0000, 4'b0100, 1, 0, 0);
    add(0, 1, 2'b11, 0, 4'b0000, 4'b1011, 1, 0, 0);
    add(0, 0, 2'b00, 0, 4'b0000, 4'b1011, 0, 1, 1);
    add(0, 1, 2'b11, 0, 4'b0000, 4'b1011, 0, 1, 1);
    add(1, 0, 2'b00, 5, 4'b0110, 4'b0001, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0100, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0011, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0110, 1, 0, 0);
    add(0, 0, 2'b00, 0, 4'b0000, 4'b0110, 0, 1, 1);
    add(1, 0, 2'b00, 5, 4'b0111, 4'b0001, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0100, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0011, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'b0000, 4'b0110, 1, 0, 0);
    add(0, 0, 2'b00, 0, 4'b0000, 4'b0110, 0, 1, 0);
    add(1, 1, 2'b11, 0, 4'b0001, 4'b0001, 1, 0, 0);
    add(0, 1, 2'b11, 0, 4'b0000, 4'b0001, 0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      npat = tbl[i].npat; golden = tbl[i].golden;
      cyc(tbl[i].start, tbl[i].en, tbl[i].din);
      chk_all($sformatf("tbl%0d", i), tbl[i].esig, tbl[i].ebusy, tbl[i].edone, tbl[i].epass);
    end

    // Gaps of two idle cycles between vectors, din toggling while en=0.
    npat = 3; golden = 4'b1011;
    cyc(1, 0, 2'b00);
    cyc(0, 1, 2'b01);
    cyc(0, 0, 2'b11); chk_all("gap_a", 4'b0011, 1, 0, 0);
    cyc(0, 0, 2'b10); chk_all("gap_b", 4'b0011, 1, 0, 0);
    cyc(0, 1, 2'b10);
    cyc(0, 0, 2'b01);
    cyc(0, 0, 2'b11); chk_all("gap_c", 4'b0100, 1, 0, 0);
    cyc(0, 1, 2'b11); chk_all("gap_last", 4'b1011, 1, 0, 0);
    cyc(0, 0, 2'b00); chk_all("gap_done", 4'b1011, 0, 1, 1);

    // Reset after two of three vectors, then en pulses, then a fresh session.
    cyc(1, 0, 2'b00);
    cyc(0, 1, 2'b01);
    cyc(0, 1, 2'b10);
    RST = 1'b0;
    cyc(0, 1, 2'b11); chk_all("rst_mid", 4'b0001, 0, 0, 0);
    RST = 1'b1;
    cyc(0, 1, 2'b11);
    cyc(0, 1, 2'b01); chk_all("rst_en_ignored", 4'b0001, 0, 0, 0);
    cyc(1, 0, 2'b00);
    cyc(0, 1, 2'b01);
    cyc(0, 1, 2'b10);
    cyc(0, 1, 2'b11);
    cyc(0, 0, 2'b00); chk_all("rst_resume", 4'b1011, 0, 1, 1);

    // start pulsed in RUN and in CHECK is ignored, including the new npat/golden.
    cyc(1, 0, 2'b00);
    cyc(0, 1, 2'b01);
    npat = 7; golden = 4'b0000;
    cyc(1, 1, 2'b10); chk_all("start_in_run", 4'b0100, 1, 0, 0);
    cyc(0, 1, 2'b11); chk_all("to_check", 4'b1011, 1, 0, 0);
    npat = 0;
    cyc(1, 1, 2'b01); chk_all("start_in_check", 4'b1011, 0, 1, 1);
    cyc(0, 0, 2'b00); chk_all("done_hold", 4'b1011, 0, 1, 1);

    // Randomized sessions with random gaps against the signature model.
    for (int s = 0; s < 40; s++) begin
      int n, exp_s, fin, g;
      int vec[$];
      n = $urandom_range(0, 12);
      fin = int'(S0);
      vec.delete();
      for (int k = 0; k < n; k++) begin
        vec.push_back($urandom_range(0, 3));
        fin = model_step(fin, vec[k]);
      end
      g = ($urandom_range(0, 1) == 1) ? fin : $urandom_range(0, 15);
      npat = CW'(n); golden = W'(g);
      cyc(1, 0, 2'($urandom_range(0, 3)));
      chk_all($sformatf("rnd%0d_start", s), S0, 1, 0, 0);
      exp_s = int'(S0);
      for (int k = 0; k < n; k++) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int j = 0; j < gaps; j++) begin
          cyc(0, 0, 2'($urandom_range(0, 3)));
          chk($sformatf("rnd%0d_gap_sig", s), 32'(sig), 32'(exp_s));
        end
        cyc(0, 1, 2'(vec[k]));
        exp_s = model_step(exp_s, vec[k]);
        chk($sformatf("rnd%0d_v%0d_sig", s, k), 32'(sig), 32'(exp_s));
      end
      chk($sformatf("rnd%0d_check_busy", s), 32'(busy), 32'd1);
      chk($sformatf("rnd%0d_check_done", s), 32'(done), 32'd0);
      cyc(0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      chk_all($sformatf("rnd%0d_end", s), W'(fin), 0, 1, fin == g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
